// File: rtl/usb_pkg.sv
// Constants and types shared by the USB full-speed RX byte assembler and TX byte loader.
package usb_pkg;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PID,
        RX_DATA,
        RX_ERR
    } rx_state_t;

    // A PID byte carries its 4-bit code in the low nibble and the complement in the high nibble.
    function automatic logic pidCheck(input logic [7:0] pidByte);
        return pidByte[3:0] == ~pidByte[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_sipo.sv
// 8-bit LSB-first serial-to-parallel window with synchronous clear.
module usb_rx_sipo (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic       bit_i,
    output logic [7:0] next_o
);

    logic [7:0] window_q;
    logic [7:0] window_d;

    // next_o is the window as it will look once the current bit is shifted in, so the
    // caller can act on a completed byte in the same cycle as the strobe.
    always_comb begin
        next_o   = {bit_i, window_q[7:1]};
        window_d = window_q;
        if (clear_i) begin
            window_d = '0;
        end else if (shift_i) begin
            window_d = next_o;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// USB full-speed RX byte assembler: SYNC hunt, PID capture/check, byte delivery and EOP status.
module usb_rx_byte_assembler
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 66,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             shift_enable,
    input  logic             d_bit,
    input  logic             d_eop,
    output logic [7:0]       rx_data,
    output logic             byte_ready,
    output logic [3:0]       rx_pid,
    output logic             pid_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic             rx_active,
    output logic             packet_done,
    output logic             rx_error
);

    rx_state_t        state_q, state_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [CNT_W-1:0] byteCount_q, byteCount_d;
    logic [7:0]       rxData_q, rxData_d;
    logic [3:0]       rxPid_q, rxPid_d;
    logic             pidValid_q, pidValid_d;
    logic             rxActive_q, rxActive_d;
    logic             rxError_q, rxError_d;
    logic             byteReady_q, byteReady_d;
    logic             packetDone_q, packetDone_d;

    logic       shiftEn;
    logic       lastBit;
    logic       byteFull;
    logic       windowClear;
    logic [7:0] winNext;

    // An EOP coinciding with a bit strobe takes priority and the bit is dropped.
    assign shiftEn     = shift_enable & ~d_eop;
    assign lastBit     = (bitCnt_q == 3'd7);
    assign byteFull    = (byteCount_q == CNT_W'(MAX_BYTES));
    assign windowClear = (state_d == RX_IDLE) && (state_q != RX_IDLE);

    usb_rx_sipo uSipo (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (windowClear),
        .shift_i (shiftEn && (state_q != RX_ERR)),
        .bit_i   (d_bit),
        .next_o  (winNext)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: if (shiftEn && (winNext == SYNC_PATTERN)) state_d = RX_PID;
            RX_PID: begin
                if (d_eop) state_d = RX_IDLE;
                else if (shiftEn && lastBit) state_d = pidCheck(winNext) ? RX_DATA : RX_ERR;
            end
            RX_DATA: begin
                if (d_eop) state_d = RX_IDLE;
                else if (shiftEn && lastBit && byteFull) state_d = RX_ERR;
            end
            RX_ERR: if (d_eop) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    // Datapath next-state; the bit counter restarts on every state change.
    always_comb begin
        bitCnt_d     = bitCnt_q;
        byteCount_d  = byteCount_q;
        rxData_d     = rxData_q;
        rxPid_d      = rxPid_q;
        pidValid_d   = pidValid_q;
        rxActive_d   = rxActive_q;
        rxError_d    = rxError_q;
        byteReady_d  = 1'b0;
        packetDone_d = 1'b0;

        if (state_d != state_q) begin
            bitCnt_d = 3'd0;
        end else if (shiftEn) begin
            bitCnt_d = bitCnt_q + 3'd1;
        end

        case (state_q)
            RX_IDLE: begin
                if (shiftEn && (winNext == SYNC_PATTERN)) begin
                    rxActive_d  = 1'b1;
                    rxError_d   = 1'b0;
                    pidValid_d  = 1'b0;
                    byteCount_d = '0;
                end
            end
            RX_PID: begin
                if (d_eop) begin
                    rxError_d  = 1'b1;
                    rxActive_d = 1'b0;
                end else if (shiftEn && lastBit) begin
                    if (pidCheck(winNext)) begin
                        rxPid_d    = winNext[3:0];
                        pidValid_d = 1'b1;
                    end else begin
                        rxError_d = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (d_eop) begin
                    rxActive_d = 1'b0;
                    if (bitCnt_q == 3'd0) packetDone_d = 1'b1;
                    else                  rxError_d    = 1'b1;
                end else if (shiftEn && lastBit) begin
                    if (byteFull) begin
                        rxError_d = 1'b1;
                    end else begin
                        rxData_d    = winNext;
                        byteReady_d = 1'b1;
                        byteCount_d = byteCount_q + CNT_W'(1);
                    end
                end
            end
            RX_ERR: if (d_eop) rxActive_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bitCnt_q     <= '0;
            byteCount_q  <= '0;
            rxData_q     <= '0;
            rxPid_q      <= '0;
            pidValid_q   <= 1'b0;
            rxActive_q   <= 1'b0;
            rxError_q    <= 1'b0;
            byteReady_q  <= 1'b0;
            packetDone_q <= 1'b0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            byteCount_q  <= byteCount_d;
            rxData_q     <= rxData_d;
            rxPid_q      <= rxPid_d;
            pidValid_q   <= pidValid_d;
            rxActive_q   <= rxActive_d;
            rxError_q    <= rxError_d;
            byteReady_q  <= byteReady_d;
            packetDone_q <= packetDone_d;
        end
    end

    assign rx_data     = rxData_q;
    assign byte_ready  = byteReady_q;
    assign rx_pid      = rxPid_q;
    assign pid_valid   = pidValid_q;
    assign byte_count  = byteCount_q;
    assign rx_active   = rxActive_q;
    assign packet_done = packetDone_q;
    assign rx_error    = rxError_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Directed bench for usb_rx_byte_assembler: packet vector table plus hand-written corner sequences.
module tb_usb_rx_byte_assembler;

    logic clk = 1'b0;
    logic n_rst;
    logic shift_enable;
    logic d_bit;
    logic d_eop;

    logic [7:0] rx_data;
    logic       byte_ready;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic [6:0] byte_count;
    logic       rx_active;
    logic       packet_done;
    logic       rx_error;

    logic [7:0] oRxData;
    logic       oByteReady;
    logic [3:0] oRxPid;
    logic       oPidValid;
    logic [1:0] oByteCount;
    logic       oRxActive;
    logic       oPacketDone;
    logic       oRxError;

    int vectors     = 0;
    int miscompares = 0;

    int         readyCnt    = 0;
    int         doneCnt     = 0;
    int         ovfReadyCnt = 0;
    int         ovfDoneCnt  = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    usb_rx_byte_assembler #(.MAX_BYTES(66), .CNT_W(7)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .d_bit        (d_bit),
        .d_eop        (d_eop),
        .rx_data      (rx_data),
        .byte_ready   (byte_ready),
        .rx_pid       (rx_pid),
        .pid_valid    (pid_valid),
        .byte_count   (byte_count),
        .rx_active    (rx_active),
        .packet_done  (packet_done),
        .rx_error     (rx_error)
    );

    usb_rx_byte_assembler #(.MAX_BYTES(2), .CNT_W(2)) dutOvf (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .d_bit        (d_bit),
        .d_eop        (d_eop),
        .rx_data      (oRxData),
        .byte_ready   (oByteReady),
        .rx_pid       (oRxPid),
        .pid_valid    (oPidValid),
        .byte_count   (oByteCount),
        .rx_active    (oRxActive),
        .packet_done  (oPacketDone),
        .rx_error     (oRxError)
    );

    always @(negedge clk) begin
        if (byte_ready) begin
            readyCnt++;
            got.push_back(rx_data);
        end
        if (packet_done) doneCnt++;
        if (oByteReady)  ovfReadyCnt++;
        if (oPacketDone) ovfDoneCnt++;
    end

    typedef struct {
        string       name;
        logic [7:0]  pid;
        int          nBits;
        logic [31:0] payload;
        logic [3:0]  expPid;
        logic        expValid;
        logic        expErr;
        int          expDone;
        int          expReady;
        int          expCount;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b, input logic eop);
        shift_enable = 1'b1;
        d_bit        = b;
        d_eop        = eop;
        @(negedge clk);
        shift_enable = 1'b0;
        d_bit        = 1'b0;
        d_eop        = 1'b0;
    endtask

    task automatic sendBits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) sendBit(v[i], 1'b0);
    endtask

    task automatic sendEop();
        d_eop = 1'b1;
        @(negedge clk);
        d_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearCounts();
        readyCnt    = 0;
        doneCnt     = 0;
        ovfReadyCnt = 0;
        ovfDoneCnt  = 0;
        got.delete();
    endtask

    task automatic applyStimulus(input vec_t v);
        clearCounts();
        sendBits(32'h80, 8);
        sendBits({24'h0, v.pid}, 8);
        checkOutput({v.name, " rx_active mid"}, 32'(rx_active), 32'd1);
        sendBits(v.payload, v.nBits);
        sendEop();
        idle(2);
        checkOutput({v.name, " rx_pid"},     32'(rx_pid),     32'(v.expPid));
        checkOutput({v.name, " pid_valid"},  32'(pid_valid),  32'(v.expValid));
        checkOutput({v.name, " rx_error"},   32'(rx_error),   32'(v.expErr));
        checkOutput({v.name, " done"},       32'(doneCnt),    32'(v.expDone));
        checkOutput({v.name, " ready"},      32'(readyCnt),   32'(v.expReady));
        checkOutput({v.name, " byte_count"}, 32'(byte_count), 32'(v.expCount));
        checkOutput({v.name, " rx_data"},    32'(rx_data),    32'(v.expData));
        checkOutput({v.name, " rx_active"},  32'(rx_active),  32'd0);
        for (int k = 0; k < v.expReady && k < got.size(); k++) begin
            checkOutput($sformatf("%s byte%0d", v.name, k), 32'(got[k]), 32'(v.payload[8*k +: 8]));
        end
    endtask

    initial begin
        vecs[0] = '{"data0",  8'hC3, 32, 32'h0000_3CA5, 4'h3, 1'b1, 1'b0, 1, 4, 4, 8'h00};
        vecs[1] = '{"ack",    8'hD2,  0, 32'h0,         4'h2, 1'b1, 1'b0, 1, 0, 0, 8'h00};
        vecs[2] = '{"badpid", 8'hC4, 16, 32'h0000_BEEF, 4'h2, 1'b0, 1'b1, 0, 0, 0, 8'h00};
        vecs[3] = '{"trunc",  8'hC3,  5, 32'h0000_0016, 4'h3, 1'b1, 1'b1, 0, 0, 0, 8'h00};
        vecs[4] = '{"data1",  8'h4B, 16, 32'h0000_5A96, 4'hB, 1'b1, 1'b0, 1, 2, 2, 8'h5A};
        vecs[5] = '{"in",     8'h69, 16, 32'h0000_1234, 4'h9, 1'b1, 1'b0, 1, 2, 2, 8'h12};

        n_rst        = 1'b0;
        shift_enable = 1'b0;
        d_bit        = 1'b0;
        d_eop        = 1'b0;
        idle(3);
        checkOutput("reset outputs",
                    {rx_data, byte_ready, rx_pid, pid_valid, byte_count, rx_active, packet_done, rx_error},
                    32'd0);
        n_rst = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // EOP together with the 8th data bit: errored EOP, no byte.
        clearCounts();
        sendBits(32'h80, 8);
        sendBits(32'hC3, 8);
        sendBits(32'h7F, 7);
        sendBit(1'b1, 1'b1);
        idle(2);
        checkOutput("coinc rx_error",   32'(rx_error),   32'd1);
        checkOutput("coinc ready",      32'(readyCnt),   32'd0);
        checkOutput("coinc done",       32'(doneCnt),    32'd0);
        checkOutput("coinc byte_count", 32'(byte_count), 32'd0);
        checkOutput("coinc rx_active",  32'(rx_active),  32'd0);

        // Idle-line zeros never form SYNC; EOP in IDLE leaves the sticky error alone.
        clearCounts();
        sendBits(32'h0, 24);
        sendEop();
        idle(2);
        checkOutput("noise rx_active", 32'(rx_active), 32'd0);
        checkOutput("noise rx_error",  32'(rx_error),  32'd1);
        checkOutput("noise done",      32'(doneCnt),   32'd0);

        applyStimulus(vecs[0]);

        // Overflow: the MAX_BYTES=2 instance takes two bytes and errors on the third.
        clearCounts();
        sendBits(32'h80, 8);
        sendBits(32'hC3, 8);
        sendBits(32'h0033_2211, 24);
        idle(1);
        checkOutput("ovf ready",      32'(ovfReadyCnt), 32'd2);
        checkOutput("ovf rx_error",   32'(oRxError),    32'd1);
        checkOutput("ovf byte_count", 32'(oByteCount),  32'd2);
        checkOutput("ovf rx_active",  32'(oRxActive),   32'd1);
        checkOutput("ovf rx_data",    32'(oRxData),     32'h22);
        checkOutput("ovf main ready", 32'(readyCnt),    32'd3);
        sendEop();
        idle(2);
        checkOutput("ovf done",        32'(ovfDoneCnt), 32'd0);
        checkOutput("ovf active end",  32'(oRxActive),  32'd0);
        checkOutput("ovf main done",   32'(doneCnt),    32'd1);

        // Reset in the middle of DATA clears everything asynchronously.
        clearCounts();
        sendBits(32'h80, 8);
        sendBits(32'hC3, 8);
        sendBits(32'h0000_0FA5, 12);
        checkOutput("prereset rx_data",    32'(rx_data),    32'hA5);
        checkOutput("prereset byte_count", 32'(byte_count), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midreset outputs",
                    {rx_data, byte_ready, rx_pid, pid_valid, byte_count, rx_active, packet_done, rx_error},
                    32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        sendBits(32'h0000_000F, 4);
        sendEop();
        idle(2);
        checkOutput("postreset ready", 32'(readyCnt),  32'd1);
        checkOutput("postreset done",  32'(doneCnt),   32'd0);
        checkOutput("postreset active", 32'(rx_active), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
